// File: rtl/cpu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_if
// Brief    : Control bundle between cpu_ctrl_fsm and the CR16-style datapath.
// Revision : 1.0  initial release
// ============================================================================
interface cpu_ctrl_if #(
  parameter int NREGS = 16,
  parameter int PSR_W = 5
);
  logic             run;
  logic [3:0]       op_hi;
  logic [3:0]       op_ext;
  logic [3:0]       rdst_f;
  logic [PSR_W-1:0] alu_flags;
  logic             ir_en;
  logic             pc_en;
  logic             branch;
  logic             jump;
  logic             imm_sel;
  logic             addr_sel;
  logic             bus_sel;
  logic             mem_we;
  logic [NREGS-1:0] reg_en;
  logic [PSR_W-1:0] psr;
  logic             illegal;
  logic [2:0]       state;

  modport master (
    input  run, op_hi, op_ext, rdst_f, alu_flags,
    output ir_en, pc_en, branch, jump, imm_sel, addr_sel, bus_sel,
           mem_we, reg_en, psr, illegal, state
  );

  modport slave (
    output run, op_hi, op_ext, rdst_f, alu_flags,
    input  ir_en, pc_en, branch, jump, imm_sel, addr_sel, bus_sel,
           mem_we, reg_en, psr, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_fsm
// Brief    : Multi-cycle fetch/decode/execute/write-back control unit with PSR.
// Revision : 1.0  initial release
// ============================================================================
module cpu_ctrl_fsm #(
  parameter int NREGS = 16,
  parameter int PSR_W = 5
) (
  input  wire logic    clk,
  input  wire logic    rst,
  cpu_ctrl_if.master   ctrl
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_LDWB   = 3'd3;

  logic [2:0]       r_state;
  logic [PSR_W-1:0] r_psr;

  logic [2:0]       w_next;
  logic             w_ir_en;
  logic             w_pc_en;
  logic             w_branch;
  logic             w_jump;
  logic             w_imm_sel;
  logic             w_addr_sel;
  logic             w_bus_sel;
  logic             w_mem_we;
  logic             w_illegal;
  logic             w_psr_we;
  logic [NREGS-1:0] w_reg_en;
  logic [NREGS-1:0] w_onehot;
  logic             w_cond;

  assign w_onehot = {{(NREGS-1){1'b0}}, 1'b1} << ctrl.rdst_f;

  // Condition codes read the latched PSR so a branch sees the preceding CMP.
  always_comb begin
    w_cond = 1'b0;
    case (ctrl.rdst_f)
      4'b0000: w_cond =  r_psr[1];
      4'b0001: w_cond = ~r_psr[1];
      4'b0010: w_cond =  r_psr[4];
      4'b0011: w_cond = ~r_psr[4];
      4'b0100: w_cond =  r_psr[3];
      4'b0101: w_cond = ~r_psr[3];
      4'b0110: w_cond =  r_psr[0];
      4'b0111: w_cond = ~r_psr[0];
      4'b1000: w_cond =  r_psr[2];
      4'b1001: w_cond = ~r_psr[2];
      4'b1010: w_cond = ~r_psr[3] & ~r_psr[1];
      4'b1011: w_cond =  r_psr[3] |  r_psr[1];
      4'b1100: w_cond = ~r_psr[0] & ~r_psr[1];
      4'b1101: w_cond =  r_psr[0] |  r_psr[1];
      4'b1110: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_ir_en    = 1'b0;
    w_pc_en    = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_imm_sel  = 1'b0;
    w_addr_sel = 1'b0;
    w_bus_sel  = 1'b0;
    w_mem_we   = 1'b0;
    w_illegal  = 1'b0;
    w_psr_we   = 1'b0;
    w_reg_en   = '0;
    if (!rst) begin
      // While reset is asserted present FETCH outputs so no strobe escapes.
      w_addr_sel = 1'b1;
    end else begin
      case (r_state)
        S_FETCH: begin
          w_addr_sel = 1'b1;
          if (ctrl.run) w_next = S_DECODE;
        end
        S_DECODE: begin
          w_addr_sel = 1'b1;
          w_ir_en    = 1'b1;
          w_next     = S_EXEC;
        end
        S_EXEC: begin
          w_next = S_FETCH;
          if (ctrl.op_hi == 4'b0100) begin
            case (ctrl.op_ext)
              4'b0000: w_next = S_LDWB;
              4'b0100: begin
                w_mem_we = 1'b1;
                w_pc_en  = 1'b1;
              end
              4'b1100: begin
                w_pc_en = 1'b1;
                w_jump  = w_cond;
              end
              default: begin
                w_pc_en   = 1'b1;
                w_illegal = 1'b1;
              end
            endcase
          end else begin
            case (ctrl.op_hi)
              4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101,
              4'b1001, 4'b1011, 4'b1101, 4'b1111: begin
                w_reg_en  = w_onehot;
                w_psr_we  = 1'b1;
                w_pc_en   = 1'b1;
                w_imm_sel = (ctrl.op_hi != 4'b0000);
              end
              4'b1000: begin
                w_reg_en  = w_onehot;
                w_psr_we  = 1'b1;
                w_pc_en   = 1'b1;
                w_imm_sel = (ctrl.op_ext[3:1] == 3'b000);
              end
              4'b1100: begin
                w_pc_en  = 1'b1;
                w_branch = w_cond;
              end
              default: begin
                w_pc_en   = 1'b1;
                w_illegal = 1'b1;
              end
            endcase
          end
        end
        S_LDWB: begin
          w_bus_sel = 1'b1;
          w_reg_en  = w_onehot;
          w_pc_en   = 1'b1;
          w_next    = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_psr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_psr_we) r_psr <= ctrl.alu_flags;
    end
  end

  assign ctrl.ir_en    = w_ir_en;
  assign ctrl.pc_en    = w_pc_en;
  assign ctrl.branch   = w_branch;
  assign ctrl.jump     = w_jump;
  assign ctrl.imm_sel  = w_imm_sel;
  assign ctrl.addr_sel = w_addr_sel;
  assign ctrl.bus_sel  = w_bus_sel;
  assign ctrl.mem_we   = w_mem_we;
  assign ctrl.reg_en   = w_reg_en;
  assign ctrl.illegal  = w_illegal;
  assign ctrl.psr      = r_psr;
  assign ctrl.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ctrl_fsm
// Brief    : Directed vector bench for cpu_ctrl_fsm.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic [2:0]  st;
    logic        ir;
    logic        pc;
    logic        br;
    logic        jp;
    logic        imm;
    logic        addr;
    logic        bus;
    logic        we;
    logic        ill;
    logic [15:0] re;
    logic [4:0]  psr;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [3:0] oph;
    logic [3:0] ope;
    logic [3:0] rd;
    logic [4:0] fl;
    outs_t      exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vq[$];

  cpu_ctrl_if #(.NREGS(16), .PSR_W(5)) u_if ();

  cpu_ctrl_fsm #(.NREGS(16), .PSR_W(5)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t mk(input logic [2:0] st, input logic ir, input logic pc,
                               input logic br, input logic jp, input logic imm,
                               input logic ad, input logic bs, input logic we,
                               input logic il, input logic [15:0] re, input logic [4:0] ps);
    outs_t o;
    o.st = st; o.ir = ir; o.pc = pc; o.br = br; o.jp = jp; o.imm = imm;
    o.addr = ad; o.bus = bs; o.we = we; o.ill = il; o.re = re; o.psr = ps;
    return o;
  endfunction

  function automatic outs_t f_st(input logic [4:0] ps);
    return mk(3'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, ps);
  endfunction

  function automatic outs_t d_st(input logic [4:0] ps);
    return mk(3'd1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, ps);
  endfunction

  task automatic add(input logic r, input logic rn, input logic [3:0] oph,
                     input logic [3:0] ope, input logic [3:0] rd,
                     input logic [4:0] fl, input outs_t e);
    vec_t v;
    v.rst = r; v.run = rn; v.oph = oph; v.ope = ope; v.rd = rd; v.fl = fl; v.exp = e;
    vq.push_back(v);
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
  task automatic step(input string nm, input logic r, input logic rn,
                      input logic [3:0] oph, input logic [3:0] ope,
                      input logic [3:0] rd, input logic [4:0] fl, input outs_t e);
    outs_t act;
    rst = r;
    u_if.run = rn;
    u_if.op_hi = oph;
    u_if.op_ext = ope;
    u_if.rdst_f = rd;
    u_if.alu_flags = fl;
    #1;
    act = mk(u_if.state, u_if.ir_en, u_if.pc_en, u_if.branch, u_if.jump,
             u_if.imm_sel, u_if.addr_sel, u_if.bus_sel, u_if.mem_we,
             u_if.illegal, u_if.reg_en, u_if.psr);
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d ir=%b pc=%b br=%b jp=%b imm=%b addr=%b bus=%b we=%b ill=%b re=%h psr=%b, expected st=%0d ir=%b pc=%b br=%b jp=%b imm=%b addr=%b bus=%b we=%b ill=%b re=%h psr=%b",
               nm, act.st, act.ir, act.pc, act.br, act.jp, act.imm, act.addr, act.bus,
               act.we, act.ill, act.re, act.psr, e.st, e.ir, e.pc, e.br, e.jp, e.imm,
               e.addr, e.bus, e.we, e.ill, e.re, e.psr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // reset + ADD r3 (Z flag)
    add(0, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00000));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00000));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00000));
    add(1, 1, 4'h0, 4'h0, 4'h3, 5'b00010, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 5'b00000));
    // LOAD r5: flags on the bus must not reach the PSR
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'h4, 4'h0, 4'h5, 5'b11111, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 5'b00010));
    add(1, 1, 4'h4, 4'h0, 4'h5, 5'b11111, mk(3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 16'h0020, 5'b00010));
    // STOR
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'h4, 4'h4, 4'h5, 5'b11111, mk(2, 0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 5'b00010));
    // Bcond EQ taken
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'hC, 4'h0, 4'h0, 5'b00000, mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 5'b00010));
    // Bcond NE not taken
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'hC, 4'h0, 4'h1, 5'b00000, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 5'b00010));
    // Jcond UC
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'h4, 4'hC, 4'hE, 5'b00000, mk(2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 16'h0000, 5'b00010));
    // Jcond never
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'h4, 4'hC, 4'hF, 5'b00000, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 5'b00010));
    // illegal op_hi=0110
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'h6, 4'h0, 4'h3, 5'b11111, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 5'b00010));
    // ALU immediate into r15
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00010));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00010));
    add(1, 1, 4'h1, 4'h0, 4'hF, 5'b10001, mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 16'h8000, 5'b00010));
    // register shift into r0
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b10001));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b10001));
    add(1, 1, 4'h8, 4'h2, 4'h0, 5'b00001, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0001, 5'b10001));
    // Bcond GT on N, live flags differ
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00001));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00001));
    add(1, 1, 4'hC, 4'h0, 4'h6, 5'b00010, mk(2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 5'b00001));
    // immediate shift into r4
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00001));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00001));
    add(1, 1, 4'h8, 4'h1, 4'h4, 5'b00000, mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 16'h0010, 5'b00001));
    // JAL is unsupported
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00000));
    add(1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00000));
    add(1, 1, 4'h4, 4'h8, 4'h2, 5'b11111, mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 5'b00000));

    rst = 1'b0;
    u_if.run = 1'b1;
    u_if.op_hi = 4'h0;
    u_if.op_ext = 4'h0;
    u_if.rdst_f = 4'h0;
    u_if.alu_flags = 5'b00000;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) begin
      step($sformatf("vec%0d", i), vq[i].rst, vq[i].run, vq[i].oph, vq[i].ope,
           vq[i].rd, vq[i].fl, vq[i].exp);
    end

    // run drops during EXEC: instruction finishes, then FETCH holds
    step("hold_fetch", 1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00000));
    step("hold_decode", 1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00000));
    step("hold_exec", 1, 0, 4'h0, 4'h0, 4'h2, 5'b00100,
         mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0004, 5'b00000));
    for (int k = 0; k < 4; k++) begin
      step($sformatf("stall%0d", k), 1, 0, 4'h4, 4'h4, 4'h2, 5'b11111, f_st(5'b00100));
    end
    step("resume_fetch", 1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00100));
    step("resume_decode", 1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, d_st(5'b00100));
    // reset during a STOR execute: no strobes, then FETCH with PSR cleared
    step("rst_mid_exec", 0, 1, 4'h4, 4'h4, 4'h2, 5'b11111,
         mk(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 5'b00100));
    step("rst_after", 1, 1, 4'h0, 4'h0, 4'h0, 5'b00000, f_st(5'b00000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the 16-bit CR16-style datapath: register file, src/dst muxes, ALU, single-port BRAM (port A), program counter and instruction register.
- Sequences fetch, decode, execute, memory and write-back.
- Drives every datapath select, enable and write strobe, and holds the processor status register (PSR) that branch and jump conditions are evaluated against.

Parameters:
- NREGS, 16, number of architectural registers; reg_en width.
- PSR_W, 5, PSR width: bit4=C, bit3=L, bit2=F, bit1=Z, bit0=N.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- run  in  1  1=execute; 0=stall at next FETCH
- op_hi  in  4  IR[15:12], from instruction register
- op_ext  in  4  IR[7:4], from instruction register
- rdst_f  in  4  IR[11:8]: Rdst index, or condition code for Bcond/Jcond
- alu_flags  in  5  ALU flags, same bit order as PSR
- ir_en  out  1  instruction register load enable
- pc_en  out  1  program counter advance/load enable
- branch  out  1  PC += sign-extended displacement (qualified by pc_en)
- jump  out  1  PC <= Rsrc value (qualified by pc_en)
- imm_sel  out  1  ALU B operand: 0=Rdst, 1=immediate
- addr_sel  out  1  BRAM port A address: 1=PC, 0=Rdst value
- bus_sel  out  1  write-back bus: 0=ALU result, 1=memory data
- mem_we  out  1  BRAM port A write enable
- reg_en  out  NREGS  one-hot register write enable
- psr  out  PSR_W  latched flags
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, LDWB=3. Every output not named for a state is 0 in that state.
- Reset (rst=0 at a clock edge): state<=FETCH, psr<=0. Outputs evaluate per FETCH with pc_en=0. Reset mid-instruction abandons it with no write strobes.
- FETCH: addr_sel=1.
  - run=1: next DECODE.
  - run=0: stay in FETCH, all strobes 0.
- DECODE: addr_sel=1, ir_en=1 (IR captures BRAM q_a, which has 1-cycle read latency). Next EXEC. IR fields are valid from EXEC onward.
- EXEC, by instruction class:
  - ALU reg (op_hi=0000): reg_en[rdst_f]=1, bus_sel=0, imm_sel=0, psr<=alu_flags, pc_en=1. Next FETCH.
  - ALU imm (op_hi in 0001,0010,0011,0101,1001,1011,1101,1111): same as ALU reg but imm_sel=1.
  - Shift (op_hi=1000): as ALU. imm_sel=1 when op_ext[3:1]=000, else 0.
  - LOAD (0100/0000): addr_sel=0. Next LDWB.
  - STOR (0100/0100): addr_sel=0, mem_we=1, pc_en=1. Next FETCH.
  - Bcond (op_hi=1100): pc_en=1, branch=cond. Next FETCH.
  - Jcond (0100/1100): pc_en=1, jump=cond. Next FETCH.
  - Anything else, including JAL (0100/1000) and op_hi 0110/0111/1010/1110: pc_en=1, illegal=1, no writes. Next FETCH.
- LDWB: bus_sel=1, reg_en[rdst_f]=1, pc_en=1. Next FETCH.
- cond(rdst_f), evaluated on the latched psr, never on alu_flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L&!Z
  - 1011 HS: L|Z
  - 1100 LT: !N&!Z
  - 1101 GE: N|Z
  - 1110 UC: 1
  - 1111 never: 0
- psr updates only on ALU/shift EXEC cycles. A branch right after a CMP sees the CMP flags.
- reg_en is strictly one-hot or zero. At most one of branch/jump is 1, and only when pc_en=1.
- Latency: ALU/STOR/branch/jump/illegal = 3 cycles; LOAD = 4 cycles. Exactly one pc_en pulse per instruction.
- run deasserted mid-instruction: the current instruction completes, then the FSM holds in FETCH.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release with run=1 -> state 0,1,2,...; psr=00000; no reg_en/mem_we during reset.
- ADD (op_hi=0000, rdst_f=0011), alu_flags=00010 -> EXEC cycle 3 shows reg_en=0x0008, imm_sel=0, pc_en=1; psr=00010 afterward.
- LOAD (0100/0000, rdst_f=0101) -> EXEC addr_sel=0, no reg_en; LDWB bus_sel=1, reg_en=0x0020, pc_en=1; next state FETCH.
- STOR (0100/0100) -> EXEC mem_we=1, addr_sel=0, pc_en=1, reg_en=0; instruction completes in 3 cycles.
- psr=00010, then Bcond EQ (1100, rdst_f=0000) -> branch=1. Bcond NE -> branch=0, pc_en=1. Jcond UC -> jump=1. Code 1111 -> jump=0.
- Illegal op_hi=0110 -> illegal pulses for 1 cycle, pc_en=1, no writes. run=0 during EXEC -> FSM holds in FETCH with all strobes 0 until run=1.
